gray_position_tracker: RTL and testbench

Tracks the absolute position reported by a Gray-coded encoder (rotary or linear) that is sampled asynchronously.
- Synchronises and glitch-filters gray_in, then converts it to binary through the existing gray_to_binary converter.
- Classifies each accepted change as step up, step down or illegal jump, and maintains a signed revolution count.
- Sits between the encoder pins and the motion/control logic that consumes position and direction events.

---
 rtl/gray_tracker_pkg.sv | 5 +
 rtl/gray_input_filter.sv | 34 +++
 rtl/gray_to_binary.sv | 11 +
 rtl/gray_position_tracker.sv | 64 ++++++
 tb/tb_gray_position_tracker.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/gray_tracker_pkg.sv
// gray_tracker_pkg: shared state and step-classification types for the Gray position tracker
package gray_tracker_pkg;
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;
  typedef enum logic [1:0] {NONE, UP, DOWN, JUMP} step_t;
endpackage

// File: rtl/gray_input_filter.sv
// gray_input_filter: 2-flop synchroniser plus stability filter on the encoder input
module gray_input_filter #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] cand,
  output logic             stable
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic [WIDTH-1:0] sync1, sync2, cand_q;
  logic [CW-1:0] cnt, cnt_next;
  // the next candidate always equals the synchronised sample, so expose it directly
  assign cand = sync2;
  always_comb begin
    cnt_next = sync2 != cand_q ? CW'(1) : cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1);
    stable   = cnt_next == CW'(STABLE_CYCLES);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      cand_q <= '0;
      cnt    <= '0;
    end else begin
      sync1  <= gray_in;
      sync2  <= sync1;
      cand_q <= sync2;
      cnt    <= cnt_next;
    end
  end
endmodule

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational Gray-to-binary converter
module gray_to_binary #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign bin[g] = ^gray[WIDTH-1:g];
  end
endmodule

// File: rtl/gray_position_tracker.sv
// gray_position_tracker: filtered Gray encoder tracking with step/jump events and revolution count
module gray_position_tracker
  import gray_tracker_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int REV_WIDTH     = 8,
  parameter int ERR_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     position,
  output logic                 position_valid,
  output logic [REV_WIDTH-1:0] revolutions,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 err_jump,
  output logic [ERR_WIDTH-1:0] err_count
);
  state_t state;
  step_t step;
  logic [WIDTH-1:0] cand, bin_new, last_gray, diff;
  logic stable, accept, wrap_up, wrap_down;
  gray_input_filter #(.WIDTH(WIDTH), .STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .cand(cand), .stable(stable)
  );
  gray_to_binary #(.WIDTH(WIDTH)) u_g2b (.gray(cand), .bin(bin_new));
  always_comb begin
    accept    = en && stable && (state == ACQUIRE || (state == TRACK && cand != last_gray));
    diff      = bin_new - position;
    step      = !(accept && state == TRACK) ? NONE : diff == WIDTH'(1) ? UP : diff == '1 ? DOWN : JUMP;
    wrap_up   = step == UP && position == '1 && bin_new == '0;
    wrap_down = step == DOWN && position == '0 && bin_new == '1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      position       <= '0;
      position_valid <= 1'b0;
      revolutions    <= '0;
      step_up        <= 1'b0;
      step_down      <= 1'b0;
      err_jump       <= 1'b0;
      err_count      <= '0;
      last_gray      <= '0;
    end else begin
      state          <= !en ? IDLE : state == IDLE ? ACQUIRE : (state == ACQUIRE && accept) ? TRACK : state;
      position_valid <= en && (state == TRACK || accept);
      step_up        <= step == UP;
      step_down      <= step == DOWN;
      err_jump       <= step == JUMP;
      if (accept) begin
        position  <= bin_new;
        last_gray <= cand;
      end
      revolutions <= clear ? '0 : wrap_up ? revolutions + REV_WIDTH'(1) :
                     wrap_down ? revolutions - REV_WIDTH'(1) : revolutions;
      err_count   <= clear ? '0 : (step == JUMP && err_count != '1) ? err_count + ERR_WIDTH'(1) : err_count;
    end
  end
endmodule

// File: tb/tb_gray_position_tracker.sv
// tb_gray_position_tracker: directed table-driven checks of the Gray position tracker
module tb_gray_position_tracker;
  logic clk = 1'b0;
  logic rst_n, en, clear;
  logic [3:0] gray_in, position;
  logic position_valid, step_up, step_down, err_jump;
  logic [7:0] revolutions, err_count;
  int passed = 0, total = 0, cu, cd, cj, multi = 0, jt;
  typedef struct {
    logic [3:0] g;
    int pos, up, dn, jmp, rev, err;
  } vec_t;
  vec_t tbl[12];

  gray_position_tracker dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .gray_in(gray_in),
    .position(position), .position_valid(position_valid), .revolutions(revolutions),
    .step_up(step_up), .step_down(step_down), .err_jump(err_jump), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic hold(input logic [3:0] g, input int n);
    gray_in = g;
    cu = 0; cd = 0; cj = 0;
    repeat (n) begin
      @(negedge clk);
      cu += int'(step_up);
      cd += int'(step_down);
      cj += int'(err_jump);
      if (int'(step_up) + int'(step_down) + int'(err_jump) > 1) multi++;
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0011, 2, 1, 0, 0, 0, 0};
    tbl[1]  = '{4'b0010, 3, 1, 0, 0, 0, 0};
    tbl[2]  = '{4'b0011, 2, 0, 1, 0, 0, 0};
    tbl[3]  = '{4'b0001, 1, 0, 1, 0, 0, 0};
    tbl[4]  = '{4'b0000, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{4'b1000, 15, 0, 1, 0, 255, 0};
    tbl[6]  = '{4'b0000, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{4'b1000, 15, 0, 1, 0, 255, 0};
    tbl[8]  = '{4'b0000, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{4'b0001, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{4'b0011, 2, 1, 0, 0, 0, 0};
    tbl[11] = '{4'b0110, 4, 0, 0, 1, 0, 1};
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; gray_in = 4'b0000;
    #12;
    chk("reset position", int'(position), 0);
    chk("reset valid", int'(position_valid), 0);
    chk("reset pulses", int'(step_up) + int'(step_down) + int'(err_jump), 0);
    chk("reset revolutions", int'(revolutions), 0);
    chk("reset err_count", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    hold(4'b0000, 10);
    chk("acquire position", int'(position), 0);
    chk("acquire valid", int'(position_valid), 1);
    chk("acquire pulses", cu + cd + cj, 0);
    chk("acquire revolutions", int'(revolutions), 0);
    // latency: change seen after exactly 6 rising edges
    gray_in = 4'b0001;
    repeat (5) @(negedge clk);
    chk("latency early position", int'(position), 0);
    @(negedge clk);
    chk("latency position", int'(position), 1);
    chk("latency step_up", int'(step_up), 1);
    hold(4'b0001, 4);
    for (int i = 0; i < 12; i++) begin
      hold(tbl[i].g, 8);
      chk($sformatf("vec%0d position", i), int'(position), tbl[i].pos);
      chk($sformatf("vec%0d up", i), cu, tbl[i].up);
      chk($sformatf("vec%0d down", i), cd, tbl[i].dn);
      chk($sformatf("vec%0d jump", i), cj, tbl[i].jmp);
      chk($sformatf("vec%0d revolutions", i), int'(revolutions), tbl[i].rev);
      chk($sformatf("vec%0d err_count", i), int'(err_count), tbl[i].err);
    end
    hold(4'b0111, 3);
    hold(4'b0110, 8);
    chk("glitch position", int'(position), 4);
    chk("glitch pulses", cu + cd + cj, 0);
    jt = 0;
    for (int k = 0; k < 260; k++) begin
      hold(k % 2 == 0 ? 4'b0000 : 4'b0110, 7);
      jt += cj;
    end
    chk("sat jumps", jt, 260);
    chk("sat err_count", int'(err_count), 255);
    chk("sat position", int'(position), 4);
    hold(4'b1000, 8);
    chk("jump to 15 position", int'(position), 15);
    hold(4'b0000, 8);
    chk("wrap up step", cu, 1);
    chk("wrap up revolutions", int'(revolutions), 1);
    hold(4'b0110, 8);
    hold(4'b1000, 8);
    chk("pre-clear revolutions", int'(revolutions), 1);
    chk("pre-clear err_count", int'(err_count), 255);
    gray_in = 4'b0000;
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear step_up", int'(step_up), 1);
    chk("clear position", int'(position), 0);
    chk("clear revolutions", int'(revolutions), 0);
    chk("clear err_count", int'(err_count), 0);
    hold(4'b0000, 4);
    en = 1'b0;
    @(negedge clk);
    chk("disable valid", int'(position_valid), 0);
    hold(4'b0001, 8);
    chk("disabled position hold", int'(position), 0);
    chk("disabled pulses", cu + cd + cj, 0);
    en = 1'b1;
    hold(4'b0001, 8);
    chk("reenable position", int'(position), 1);
    chk("reenable valid", int'(position_valid), 1);
    chk("reenable pulses", cu + cd + cj, 0);
    gray_in = 4'b0011;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset position", int'(position), 0);
    chk("midreset valid", int'(position_valid), 0);
    chk("midreset pulses", int'(step_up) + int'(step_down) + int'(err_jump), 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b0011, 10);
    chk("reacquire position", int'(position), 2);
    chk("reacquire valid", int'(position_valid), 1);
    chk("reacquire pulses", cu + cd + cj, 0);
    chk("exclusive pulses", multi, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
